// File: rtl/adder_pkg.sv
// Shared constants and bit-level generate/propagate helpers for the lookahead adders.
package adder_pkg;

  localparam int WIDTH  = 32;
  localparam int GROUP  = 4;
  localparam int NGROUP = WIDTH / GROUP;

  function automatic logic [GROUP-1:0] gen_bits(input logic [GROUP-1:0] a,
                                                input logic [GROUP-1:0] b);
    return a & b;
  endfunction

  function automatic logic [GROUP-1:0] prop_bits(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/cla4_block.sv
// 4-bit carry-lookahead slice: intra-group carries in two-level form plus group G/P
// for the second-level lookahead in the top.
module cla4_block
  import adder_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic [GROUP-1:0] c,
  output logic             G,
  output logic             P
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;

  assign g = gen_bits(a, b);
  assign p = prop_bits(a, b);

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign s = p ^ c;

endmodule

// File: rtl/adder_lc_32bit.sv
// 32-bit two-level carry-lookahead adder with a combinational result and a
// one-cycle registered copy; optional debug port exposes every bit's carry-in.
module adder_lc_32bit
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef ADD_DEBUG_ON
  ,
  output logic [WIDTH-1:0] debug
`endif
);

  logic [NGROUP-1:0] grp_g;
  logic [NGROUP-1:0] grp_p;
  logic [NGROUP:0]   grp_c;
  logic [WIDTH-1:0]  carry;

  for (genvar k = 0; k < NGROUP; k++) begin : g_blk
    cla4_block u_cla4 (
      .a  (op1[k*GROUP +: GROUP]),
      .b  (op2[k*GROUP +: GROUP]),
      .ci (grp_c[k]),
      .s  (sum[k*GROUP +: GROUP]),
      .c  (carry[k*GROUP +: GROUP]),
      .G  (grp_g[k]),
      .P  (grp_p[k])
    );
  end

  // Each group carry is a flat OR of products (G_j & P_{j+1..k}) plus cin & P_{0..k},
  // so no group carry waits on another.
  always_comb begin
    logic acc;
    logic term;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int k = 0; k < NGROUP; k++) begin
      acc = cin;
      for (int m = 0; m <= k; m++) acc = acc & grp_p[m];
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end
  end

  assign cout = grp_c[NGROUP];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

`ifdef ADD_DEBUG_ON
  assign debug = carry;
`else
  logic unused_carry;
  assign unused_carry = ^carry;
`endif

endmodule

// File: tb/tb_adder_lc_32bit.sv
// Self-checking bench: directed corner cases plus random vectors against a plain
// 33-bit arithmetic reference, covering both combinational and registered outputs.
module tb_adder_lc_32bit;

  logic        clk;
  logic        rst;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        cin;
  logic [31:0] sum;
  logic        cout;
  logic [31:0] sum_q;
  logic        cout_q;
`ifdef ADD_DEBUG_ON
  logic [31:0] debug;
`endif

  int n_checks;
  int n_errors;

  adder_lc_32bit dut (
    .clk    (clk),
    .rst    (rst),
    .op1    (op1),
    .op2    (op2),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef ADD_DEBUG_ON
    ,
    .debug  (debug)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    longint unsigned t;
    t = longint'(a) + longint'(b) + longint'(c);
    return t[32:0];
  endfunction

  // Carry into bit i is bit i of the sum of the operands truncated below bit i.
  function automatic logic [31:0] ref_carries(input logic [31:0] a, input logic [31:0] b,
                                              input logic c);
    logic [31:0]     r;
    longint unsigned mask;
    longint unsigned t;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      mask = (64'd1 << i) - 64'd1;
      t = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
      r[i] = t[i];
    end
    return r;
  endfunction

  task automatic apply_comb(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c);
    op1 = a;
    op2 = b;
    cin = c;
    #1;
    check(tag, {cout, sum}, ref_add(a, b, c));
`ifdef ADD_DEBUG_ON
    check({tag, "_dbg"}, {1'b0, debug}, {1'b0, ref_carries(a, b, c)});
`endif
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [32:0] exp_q;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    op1 = '0;
    op2 = '0;
    cin = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", {cout_q, sum_q}, 33'h0);

    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      a = 32'h1 << i;
      apply_comb($sformatf("walk%0d_c0", i), a, a, 1'b0);
      check($sformatf("walk%0d_c0_cout", i), {32'h0, cout}, {32'h0, (i == 31)});
      apply_comb($sformatf("walk%0d_c1", i), a, a, 1'b1);
    end

    apply_comb("msb_c0", 32'h80000000, 32'h80000000, 1'b0);
    check("msb_c0_const", {cout, sum}, {1'b1, 32'h00000000});
    apply_comb("msb_c1", 32'h80000000, 32'h80000000, 1'b1);
    check("msb_c1_const", {cout, sum}, {1'b1, 32'h00000001});
    apply_comb("prop_c0", 32'hFFFF0000, 32'h0000FFFF, 1'b0);
    check("prop_c0_const", {cout, sum}, {1'b0, 32'hFFFFFFFF});
    apply_comb("prop_c1", 32'hFFFF0000, 32'h0000FFFF, 1'b1);
    check("prop_c1_const", {cout, sum}, {1'b1, 32'h00000000});
    apply_comb("zero_c0", 32'h0, 32'h0, 1'b0);
    check("zero_c0_const", {cout, sum}, 33'h0);
    apply_comb("zero_c1", 32'h0, 32'h0, 1'b1);
    check("zero_c1_const", {cout, sum}, 33'h1);
`ifdef ADD_DEBUG_ON
    check("zero_c1_dbg_const", {1'b0, debug}, 33'h1);
`endif

    // rst leaves the combinational path alone
    check("rst_comb", {cout, sum}, 33'h1);
    check("rst_hold_q", {cout_q, sum_q}, 33'h0);

    // Release reset and capture a known sum
    @(negedge clk);
    rst = 1'b0;
    apply_comb("reg_vec", 32'h12345678, 32'h11111111, 1'b0);
    @(posedge clk);
    #1;
    check("reg_vec_q", {cout_q, sum_q}, {1'b0, 32'h23456789});

    // Only the value present at the edge is captured
    @(negedge clk);
    apply_comb("glitch_a", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    #2;
    apply_comb("glitch_b", 32'h00000F00, 32'h000000F0, 1'b1);
    @(posedge clk);
    #1;
    check("glitch_q", {cout_q, sum_q}, {1'b0, 32'h00000FF1});

    // Mid-stream reset clears on that edge only
    @(negedge clk);
    rst = 1'b1;
    apply_comb("mid_rst", 32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
    @(posedge clk);
    #1;
    check("mid_rst_q", {cout_q, sum_q}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_q", {cout_q, sum_q}, ref_add(32'hDEADBEEF, 32'hCAFEF00D, 1'b1));

    // Random vectors, combinational and one-edge-later registered
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      c = 1'($urandom_range(1, 0));
      if (n % 16 == 0) b = ~a;
      exp_q = ref_add(a, b, c);
      apply_comb("rand_comb", a, b, c);
      @(posedge clk);
      #1;
      check("rand_q", {cout_q, sum_q}, exp_q);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
